// File: rtl/vga_console_pkg.sv
// rtl/vga_console_pkg.sv - shared opcodes, state encoding and defaults for the text console
package vga_console_pkg;

    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 30;

    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;

    localparam logic [1:0] OP_PUTC   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_SCROLL = 2'b10;
    localparam logic [1:0] OP_SETPOS = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        CLR,
        SCR_RD,
        SCR_WR,
        SCR_FILL
    } state_t;

    function automatic logic [31:0] blank_word(input logic [7:0] attr);
        return {attr, BLANK_CHAR, attr, BLANK_CHAR};
    endfunction

endpackage

// File: rtl/vga_cursor.sv
// rtl/vga_cursor.sv - cursor row/col counter with wrap, clamp and scroll request
module vga_cursor
    import vga_console_pkg::*;
#(
    parameter int COLS = COLS_DEFAULT,
    parameter int ROWS = ROWS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_pos,
    input  logic [4:0] set_row,
    input  logic [6:0] set_col,
    input  logic       home,
    input  logic       advance,
    input  logic       newline,
    input  logic       carriage,
    output logic [4:0] row,
    output logic [6:0] col,
    output logic       scroll_req
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);

    logic row_step;

    assign row_step   = newline || (advance && (col == LAST_COL));
    // The row pins at the bottom line; the controller scrolls the screen instead.
    assign scroll_req = row_step && (row == LAST_ROW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (home) begin
            row <= '0;
            col <= '0;
        end else if (set_pos) begin
            row <= (set_row > LAST_ROW) ? LAST_ROW : set_row;
            col <= (set_col > LAST_COL) ? LAST_COL : set_col;
        end else begin
            if (newline || carriage || (advance && (col == LAST_COL)))
                col <= '0;
            else if (advance)
                col <= col + 7'd1;
            if (row_step && (row != LAST_ROW))
                row <= row + 5'd1;
        end
    end

endmodule

// File: rtl/vga_console_ctrl.sv
// rtl/vga_console_ctrl.sv - text console command FSM driving a two-symbols-per-word VGA RAM
module vga_console_ctrl
    import vga_console_pkg::*;
#(
    parameter int         COLS       = COLS_DEFAULT,
    parameter int         ROWS       = ROWS_DEFAULT,
    parameter logic [7:0] CLEAR_ATTR = 8'h0F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic [10:0] vram_addr,
    input  logic [31:0] vram_rdata,
    output logic [31:0] vram_wdata,
    output logic [3:0]  vram_be,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);

    localparam logic [10:0] HALF_W    = 11'(COLS / 2);
    localparam logic [10:0] LAST_WORD = 11'(ROWS * (COLS / 2) - 1);
    localparam logic [10:0] LAST_COPY = 11'((ROWS - 1) * (COLS / 2) - 1);

    state_t      state;
    logic [10:0] cnt;
    logic [15:0] sym;
    logic        accept;
    logic        in_put;
    logic        is_lf;
    logic        is_cr;
    logic        scroll_req;
    logic [10:0] row_base;

    assign accept    = cmd_valid && (state == IDLE);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign in_put    = (state == PUT);
    assign is_lf     = (sym[7:0] == CHAR_LF);
    assign is_cr     = (sym[7:0] == CHAR_CR);
    assign row_base  = 11'(cursor_row) * HALF_W;

    vga_cursor #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .set_pos   (accept && (cmd_op == OP_SETPOS)),
        .set_row   (cmd_data[12:8]),
        .set_col   (cmd_data[6:0]),
        .home      ((state == CLR) && (cnt == LAST_WORD)),
        .advance   (in_put && !is_lf && !is_cr),
        .newline   (in_put && is_lf),
        .carriage  (in_put && is_cr),
        .row       (cursor_row),
        .col       (cursor_col),
        .scroll_req(scroll_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sym   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_PUTC: begin
                                sym   <= cmd_data;
                                state <= PUT;
                            end
                            OP_CLEAR:  state <= CLR;
                            OP_SCROLL: state <= SCR_RD;
                            default:   state <= IDLE;
                        endcase
                    end
                end
                PUT: state <= scroll_req ? SCR_RD : IDLE;
                CLR: begin
                    if (cnt == LAST_WORD)
                        state <= IDLE;
                    else
                        cnt <= cnt + 11'd1;
                end
                SCR_RD: state <= SCR_WR;
                SCR_WR: begin
                    // The counter runs straight on into the last row for the fill pass.
                    cnt   <= cnt + 11'd1;
                    state <= (cnt == LAST_COPY) ? SCR_FILL : SCR_RD;
                end
                SCR_FILL: begin
                    if (cnt == LAST_WORD)
                        state <= IDLE;
                    else
                        cnt <= cnt + 11'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        vram_addr  = '0;
        vram_wdata = '0;
        vram_be    = '0;
        case (state)
            PUT: begin
                vram_addr  = row_base + {5'b0, cursor_col[6:1]};
                vram_wdata = {sym, sym};
                if (!is_lf && !is_cr)
                    vram_be = cursor_col[0] ? 4'b0011 : 4'b1100;
            end
            CLR, SCR_FILL: begin
                vram_addr  = cnt;
                vram_wdata = blank_word(CLEAR_ATTR);
                vram_be    = 4'hF;
            end
            SCR_RD: vram_addr = cnt + HALF_W;
            SCR_WR: begin
                vram_addr  = cnt;
                vram_wdata = vram_rdata;
                vram_be    = 4'hF;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// tb/tb_vga_console_ctrl.sv - scoreboard bench with a screen-level console model
module tb_vga_console_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int HALF  = COLS / 2;
    localparam int WORDS = ROWS * HALF;
    localparam int SCROLL_CYCLES = 2 * 1160 + 40;
    localparam int CLEAR_CYCLES  = 1200;
    localparam logic [7:0]  CLEAR_ATTR = 8'h0F;
    localparam logic [15:0] BLANK = {CLEAR_ATTR, 8'h20};

    typedef struct packed {
        logic [10:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [10:0] vram_addr;
    logic [31:0] vram_rdata;
    logic [31:0] vram_wdata;
    logic [3:0]  vram_be;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    vga_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .CLEAR_ATTR(CLEAR_ATTR)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .vram_addr(vram_addr),
        .vram_rdata(vram_rdata), .vram_wdata(vram_wdata), .vram_be(vram_be),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:2047];
    logic [31:0] init_img [0:WORDS-1];
    logic        init_ram = 1'b0;

    always @(posedge clk) begin
        if (init_ram) begin
            for (int w = 0; w < WORDS; w++) ram[w] <= init_img[w];
        end else begin
            for (int b = 0; b < 4; b++)
                if (vram_be[b]) ram[vram_addr][8*b +: 8] <= vram_wdata[8*b +: 8];
        end
        vram_rdata <= ram[vram_addr];
    end

    logic [15:0] screen [ROWS][COLS];
    int cur_row, cur_col;
    wr_t exp_q[$];
    wr_t mon_e;
    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && vram_be != 4'h0) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr=%0d be=%b wdata=%h", vram_addr, vram_be, vram_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (vram_addr !== mon_e.addr || vram_be !== mon_e.be ||
                    (vram_wdata & be_mask(mon_e.be)) !== (mon_e.wdata & be_mask(mon_e.be))) begin
                    fails++;
                    $display("FAIL write: got addr=%0d be=%b wdata=%h expected addr=%0d be=%b wdata=%h",
                             vram_addr, vram_be, vram_wdata, mon_e.addr, mon_e.be, mon_e.wdata);
                end
            end
        end
    end

    task automatic push_wr(input int addr, input logic [3:0] be, input logic [31:0] wd);
        wr_t e;
        e.addr = 11'(addr);
        e.be = be;
        e.wdata = wd;
        exp_q.push_back(e);
    endtask

    task automatic model_scroll();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) screen[r][c] = screen[r+1][c];
        for (int c = 0; c < COLS; c++) screen[ROWS-1][c] = BLANK;
        for (int w = 0; w < WORDS; w++)
            push_wr(w, 4'hF, {screen[w/HALF][(w%HALF)*2], screen[w/HALF][(w%HALF)*2+1]});
    endtask

    task automatic model_row_advance(inout int exp_busy);
        if (cur_row == ROWS - 1) begin
            model_scroll();
            exp_busy += SCROLL_CYCLES;
        end else begin
            cur_row++;
        end
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [15:0] data, output int exp_busy);
        int r, c;
        exp_busy = 0;
        case (op)
            2'b00: begin
                exp_busy = 1;
                if (data[7:0] == 8'h0A) begin
                    cur_col = 0;
                    model_row_advance(exp_busy);
                end else if (data[7:0] == 8'h0D) begin
                    cur_col = 0;
                end else begin
                    if (cur_col % 2 == 0) push_wr(cur_row * HALF + cur_col / 2, 4'b1100, {data, 16'h0});
                    else                  push_wr(cur_row * HALF + cur_col / 2, 4'b0011, {16'h0, data});
                    screen[cur_row][cur_col] = data;
                    if (cur_col == COLS - 1) begin
                        cur_col = 0;
                        model_row_advance(exp_busy);
                    end else begin
                        cur_col++;
                    end
                end
            end
            2'b01: begin
                exp_busy = CLEAR_CYCLES;
                for (int rr = 0; rr < ROWS; rr++)
                    for (int cc = 0; cc < COLS; cc++) screen[rr][cc] = BLANK;
                for (int w = 0; w < WORDS; w++) push_wr(w, 4'hF, {BLANK, BLANK});
                cur_row = 0;
                cur_col = 0;
            end
            2'b10: begin
                exp_busy = SCROLL_CYCLES;
                model_scroll();
            end
            default: begin
                r = int'(data[12:8]);
                c = int'(data[6:0]);
                cur_row = (r >= ROWS) ? ROWS - 1 : r;
                cur_col = (c >= COLS) ? COLS - 1 : c;
            end
        endcase
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] data, input bit poke);
        int exp_busy, n, wait_n;
        wait_n = 0;
        @(negedge clk);
        while (!cmd_ready && wait_n < 5000) begin
            @(negedge clk);
            wait_n++;
        end
        check("ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
        model_cmd(op, data, exp_busy);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_data = 16'($urandom);
        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            if (poke && n == 10) begin
                cmd_valid = 1'b1;
                cmd_op = 2'b11;
                cmd_data = 16'h0505;
            end
            if (poke && n == 20) cmd_valid = 1'b0;
            n++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("busy_cycles", n, exp_busy);
        check("cursor_row", {27'b0, cursor_row}, cur_row);
        check("cursor_col", {25'b0, cursor_col}, cur_col);
        check("writes_drained", exp_q.size(), 0);
    endtask

    task automatic reset_mid_clear();
        @(negedge clk);
        check("ready_before_clear", {31'b0, cmd_ready}, 32'd1);
        for (int w = 0; w < 500; w++) begin
            push_wr(w, 4'hF, {BLANK, BLANK});
            screen[w/HALF][(w%HALF)*2]   = BLANK;
            screen[w/HALF][(w%HALF)*2+1] = BLANK;
        end
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_data = 16'h0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (500) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_be", {28'b0, vram_be}, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_ready", {31'b0, cmd_ready}, 32'h1);
        check("abort_addr", {21'b0, vram_addr}, 32'h0);
        check("abort_wdata", vram_wdata, 32'h0);
        check("abort_cursor", {20'b0, cursor_row, cursor_col}, 32'h0);
        cur_row = 0;
        cur_col = 0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        int r, sel;
        logic [7:0] ch;
        logic [4:0] srow;
        logic [6:0] scol;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_data = 16'h0;
        for (int w = 0; w < WORDS; w++) begin
            init_img[w] = $urandom;
            screen[w/HALF][(w%HALF)*2]   = init_img[w][31:16];
            screen[w/HALF][(w%HALF)*2+1] = init_img[w][15:0];
        end
        cur_row = 0;
        cur_col = 0;
        init_ram = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        init_ram = 1'b0;
        check("reset_be", {28'b0, vram_be}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_ready", {31'b0, cmd_ready}, 32'h1);
        check("reset_addr", {21'b0, vram_addr}, 32'h0);
        check("reset_wdata", vram_wdata, 32'h0);
        check("reset_cursor", {20'b0, cursor_row, cursor_col}, 32'h0);
        reset = 1'b0;

        issue(2'b00, 16'h1F41, 1'b0);
        issue(2'b11, 16'h034F, 1'b0);
        issue(2'b00, 16'h0F42, 1'b0);
        issue(2'b11, 16'h1D4F, 1'b0);
        issue(2'b00, 16'h0743, 1'b0);
        issue(2'b11, 16'h1F64, 1'b0);
        issue(2'b10, 16'h0000, 1'b1);
        issue(2'b00, 16'h2E0A, 1'b0);
        issue(2'b00, 16'h2E0D, 1'b0);
        issue(2'b01, 16'h0000, 1'b1);
        issue(2'b00, 16'h4E61, 1'b0);
        reset_mid_clear();

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                sel = $urandom_range(0, 9);
                if (sel == 0)      ch = 8'h0A;
                else if (sel == 1) ch = 8'h0D;
                else               ch = 8'($urandom_range(33, 126));
                issue(2'b00, {8'($urandom), ch}, 1'b0);
            end else if (r < 88) begin
                if ($urandom_range(0, 1) == 0) begin
                    srow = 5'($urandom);
                    scol = 7'($urandom);
                end else begin
                    srow = ($urandom_range(0, 2) == 0) ? 5'd31 : 5'($urandom_range(28, 29));
                    scol = 7'($urandom_range(76, 90));
                end
                issue(2'b11, {3'b0, srow, 1'b0, scol}, 1'b0);
            end else if (r < 95) begin
                issue(2'b10, 16'($urandom), 1'b0);
            end else begin
                issue(2'b01, 16'($urandom), 1'b0);
            end
        end

        repeat (2) @(negedge clk);
        for (int w = 0; w < WORDS; w++)
            check("ram_word", ram[w], {screen[w/HALF][(w%HALF)*2], screen[w/HALF][(w%HALF)*2+1]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
